layeriomem_scheduler: RTL and testbench

- Sequences a ring of TOTAL_MEMS layer-IO FIFOs shared through the slave-arbitrated FIFO bus.
- Drives its wrsel/rdsel so that the producer (post-processing writeback) fills one memory while the consumer (array input loader) drains an earlier one.
- Tracks a per-memory lifecycle state, gates both sides with ready flags, and flags protocol violations.
- Sits between the layer controller and the arbitrated FIFO bus.

---
 rtl/layeriomem_scheduler_pkg.sv | 13 +
 rtl/layeriomem_scheduler_ring_ptr.sv | 33 +++
 rtl/layeriomem_scheduler.sv | 118 +++++++++++
 tb/tb_layeriomem_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/layeriomem_scheduler_pkg.sv
// Shared types and defaults for the layer-IO memory ring scheduler.
package layeriomem_scheduler_pkg;

    localparam int _TOTAL_LAYERIOMEMS = 3;

    typedef enum logic [1:0] {
        MEM_FREE,
        MEM_WRITING,
        MEM_LOADED,
        MEM_READING
    } iomem_state_t;

endpackage

// File: rtl/layeriomem_scheduler_ring_ptr.sv
// Wrapping modulo-N pointer with advance and synchronous clear.
module layeriomem_scheduler_ring_ptr #(
    parameter int N = 3,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/layeriomem_scheduler.sv
// Sequences producer/consumer access to a ring of layer-IO memories on the arbitrated FIFO bus.
module layeriomem_scheduler
    import layeriomem_scheduler_pkg::*;
#(
    parameter int TOTAL_MEMS = _TOTAL_LAYERIOMEMS,
    localparam int SELW = $clog2(TOTAL_MEMS),
    localparam int CNTW = $clog2(TOTAL_MEMS + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            wr_start,
    input  logic            wr_last,
    input  logic            rd_start,
    input  logic            rd_last,
    input  logic            rd_keep,
    output logic [SELW-1:0] wrsel,
    output logic [SELW-1:0] rdsel,
    output logic            wr_ready,
    output logic            rd_ready,
    output logic            wr_active,
    output logic            rd_active,
    output logic [CNTW-1:0] loaded_count,
    output logic            proto_err
);

    iomem_state_t    mem_state_q [TOTAL_MEMS];
    iomem_state_t    mem_state_d [TOTAL_MEMS];
    logic            wr_active_q, wr_active_d;
    logic            rd_active_q, rd_active_d;
    logic [CNTW-1:0] loaded_count_q, loaded_count_d;
    logic            proto_err_q, proto_err_d;

    logic wr_start_ok, wr_last_ok, rd_start_ok, rd_last_ok;
    logic wr_adv, rd_adv;

    layeriomem_scheduler_ring_ptr #(.N(TOTAL_MEMS)) u_wr_ptr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (flush),
        .advance (wr_adv),
        .ptr     (wrsel)
    );

    layeriomem_scheduler_ring_ptr #(.N(TOTAL_MEMS)) u_rd_ptr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (flush),
        .advance (rd_adv),
        .ptr     (rdsel)
    );

    assign wr_ready = (mem_state_q[wrsel] == MEM_FREE) && !wr_active_q;
    assign rd_ready = (mem_state_q[rdsel] == MEM_LOADED) && !rd_active_q;

    // A last paired with an accepted start in the same cycle is a legal single-cycle transfer.
    assign wr_start_ok = wr_start && wr_ready;
    assign wr_last_ok  = wr_last && (wr_active_q || wr_start_ok);
    assign rd_start_ok = rd_start && rd_ready;
    assign rd_last_ok  = rd_last && (rd_active_q || rd_start_ok);

    always_comb begin
        mem_state_d    = mem_state_q;
        wr_active_d    = wr_active_q;
        rd_active_d    = rd_active_q;
        wr_adv         = 1'b0;
        rd_adv         = 1'b0;

        if (wr_last_ok) begin
            mem_state_d[wrsel] = MEM_LOADED;
            wr_active_d        = 1'b0;
            wr_adv             = 1'b1;
        end else if (wr_start_ok) begin
            mem_state_d[wrsel] = MEM_WRITING;
            wr_active_d        = 1'b1;
        end

        // Write and read sides never share a memory, so these updates cannot collide.
        if (rd_last_ok) begin
            mem_state_d[rdsel] = rd_keep ? MEM_LOADED : MEM_FREE;
            rd_active_d        = 1'b0;
            rd_adv             = !rd_keep;
        end else if (rd_start_ok) begin
            mem_state_d[rdsel] = MEM_READING;
            rd_active_d        = 1'b1;
        end

        loaded_count_d = loaded_count_q + CNTW'(wr_last_ok) - CNTW'(rd_last_ok && !rd_keep);

        proto_err_d = proto_err_q
                    | (wr_start && !wr_ready)
                    | (wr_last && !wr_last_ok)
                    | (rd_start && !rd_ready)
                    | (rd_last && !rd_last_ok);
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            mem_state_q    <= '{default: MEM_FREE};
            wr_active_q    <= 1'b0;
            rd_active_q    <= 1'b0;
            loaded_count_q <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            mem_state_q    <= mem_state_d;
            wr_active_q    <= wr_active_d;
            rd_active_q    <= rd_active_d;
            loaded_count_q <= loaded_count_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign wr_active    = wr_active_q;
    assign rd_active    = rd_active_q;
    assign loaded_count = loaded_count_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_layeriomem_scheduler.sv
// Self-checking bench: directed vector table plus randomized traffic against a ring model.
module tb_layeriomem_scheduler;

    localparam int N    = 3;
    localparam int SELW = $clog2(N);
    localparam int CNTW = $clog2(N + 1);

    localparam int S_FREE    = 0;
    localparam int S_WRITING = 1;
    localparam int S_LOADED  = 2;
    localparam int S_READING = 3;

    logic            clk;
    logic            resetn;
    logic            flush;
    logic            wr_start, wr_last, rd_start, rd_last, rd_keep;
    logic [SELW-1:0] wrsel, rdsel;
    logic            wr_ready, rd_ready, wr_active, rd_active;
    logic [CNTW-1:0] loaded_count;
    logic            proto_err;

    int n_cmp  = 0;
    int n_fail = 0;

    layeriomem_scheduler #(.TOTAL_MEMS(N)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .wr_start     (wr_start),
        .wr_last      (wr_last),
        .rd_start     (rd_start),
        .rd_last      (rd_last),
        .rd_keep      (rd_keep),
        .wrsel        (wrsel),
        .rdsel        (rdsel),
        .wr_ready     (wr_ready),
        .rd_ready     (rd_ready),
        .wr_active    (wr_active),
        .rd_active    (rd_active),
        .loaded_count (loaded_count),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a ring of memory states with a write head and a read head.
    int m_state [N];
    int m_wp, m_rp;
    bit m_wa, m_ra, m_err;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_state[i] = S_FREE;
        m_wp = 0; m_rp = 0; m_wa = 0; m_ra = 0; m_err = 0;
    endfunction

    function automatic bit m_wr_ready();
        return (m_state[m_wp] == S_FREE) && !m_wa;
    endfunction

    function automatic bit m_rd_ready();
        return (m_state[m_rp] == S_LOADED) && !m_ra;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++)
            if (m_state[i] == S_LOADED || m_state[i] == S_READING) c++;
        return c;
    endfunction

    function automatic void model_step(input bit ws, wl, rs, rl, rk, fl, rstn);
        bit wrdy, rrdy, ws_ok, wl_ok, rs_ok, rl_ok;
        if (!rstn || fl) begin
            model_reset();
            return;
        end
        wrdy  = m_wr_ready();
        rrdy  = m_rd_ready();
        ws_ok = ws && wrdy;
        wl_ok = wl && (m_wa || ws_ok);
        rs_ok = rs && rrdy;
        rl_ok = rl && (m_ra || rs_ok);
        if ((ws && !ws_ok) || (wl && !wl_ok) || (rs && !rs_ok) || (rl && !rl_ok)) m_err = 1;
        if (wl_ok) begin
            m_state[m_wp] = S_LOADED;
            m_wa = 0;
            m_wp = (m_wp + 1) % N;
        end else if (ws_ok) begin
            m_state[m_wp] = S_WRITING;
            m_wa = 1;
        end
        if (rl_ok) begin
            m_ra = 0;
            if (rk) begin
                m_state[m_rp] = S_LOADED;
            end else begin
                m_state[m_rp] = S_FREE;
                m_rp = (m_rp + 1) % N;
            end
        end else if (rs_ok) begin
            m_state[m_rp] = S_READING;
            m_ra = 1;
        end
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, " wrsel"},        int'(wrsel),        m_wp);
        check_output({tag, " rdsel"},        int'(rdsel),        m_rp);
        check_output({tag, " wr_ready"},     int'(wr_ready),     int'(m_wr_ready()));
        check_output({tag, " rd_ready"},     int'(rd_ready),     int'(m_rd_ready()));
        check_output({tag, " wr_active"},    int'(wr_active),    int'(m_wa));
        check_output({tag, " rd_active"},    int'(rd_active),    int'(m_ra));
        check_output({tag, " loaded_count"}, int'(loaded_count), m_count());
        check_output({tag, " proto_err"},    int'(proto_err),    int'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic apply_stimulus(input bit ws, wl, rs, rl, rk, fl, rstn, input string tag);
        wr_start = ws; wr_last = wl; rd_start = rs; rd_last = rl; rd_keep = rk;
        flush = fl; resetn = rstn;
        @(posedge clk);
        model_step(ws, wl, rs, rl, rk, fl, rstn);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit ws, wl, rs, rl, rk, fl;
        int wsel, rsel, wrdy, rrdy, wa, ra, cnt, err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input bit ws, wl, rs, rl, rk, fl,
                                    input int wsel, rsel, wrdy, rrdy, wa, ra, cnt, err);
        vec_t v;
        v.ws = ws; v.wl = wl; v.rs = rs; v.rl = rl; v.rk = rk; v.fl = fl;
        v.wsel = wsel; v.rsel = rsel; v.wrdy = wrdy; v.rrdy = rrdy;
        v.wa = wa; v.ra = ra; v.cnt = cnt; v.err = err;
        tbl.push_back(v);
    endfunction

    initial begin
        //       ws wl rs rl rk fl   wsel rsel wrdy rrdy wa ra cnt err
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);  // idle after reset
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);  // fill mem0
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1, 0);
        add_vec(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 1, 0);  // fill mem1
        add_vec(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 0,   2, 0, 1, 1, 0, 0, 2, 0);
        add_vec(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 0, 2, 0);  // fill mem2
        add_vec(0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 3, 0);  // ring full
        add_vec(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 3, 1);  // start while full
        add_vec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 0);  // flush
        add_vec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);  // overlap setup
        add_vec(0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 1, 0);
        add_vec(0, 1, 0, 1, 0, 0,   2, 1, 1, 1, 0, 0, 1, 0);  // wr_last with rd_last
        add_vec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 0);  // flush
        add_vec(1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1, 0);  // single-cycle layer
        add_vec(0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 1, 1, 0);  // multi-pass
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 0, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 0, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0);  // final pass frees mem0
        add_vec(0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 0, 0, 0);  // lone rd_keep is harmless
        add_vec(0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 1);  // rd_start with nothing loaded
        add_vec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 0);  // flush
        add_vec(1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1, 0);
        add_vec(1, 1, 0, 0, 0, 0,   2, 0, 1, 1, 0, 0, 2, 0);
        add_vec(0, 0, 1, 0, 0, 0,   2, 0, 1, 0, 0, 1, 2, 0);  // read in flight
        add_vec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 0);  // flush mid-read
        add_vec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);  // accepted after flush
        add_vec(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1);  // rd_last without a read

        wr_start = 0; wr_last = 0; rd_start = 0; rd_last = 0; rd_keep = 0;
        flush = 0; resetn = 0;
        model_reset();

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, "reset0");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, "reset1");

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply_stimulus(tbl[i].ws, tbl[i].wl, tbl[i].rs, tbl[i].rl, tbl[i].rk, tbl[i].fl, 1'b1, tag);
            check_output({tag, " tbl wrsel"},        int'(wrsel),        tbl[i].wsel);
            check_output({tag, " tbl rdsel"},        int'(rdsel),        tbl[i].rsel);
            check_output({tag, " tbl wr_ready"},     int'(wr_ready),     tbl[i].wrdy);
            check_output({tag, " tbl rd_ready"},     int'(rd_ready),     tbl[i].rrdy);
            check_output({tag, " tbl wr_active"},    int'(wr_active),    tbl[i].wa);
            check_output({tag, " tbl rd_active"},    int'(rd_active),    tbl[i].ra);
            check_output({tag, " tbl loaded_count"}, int'(loaded_count), tbl[i].cnt);
            check_output({tag, " tbl proto_err"},    int'(proto_err),    tbl[i].err);
        end

        apply_stimulus(0, 0, 0, 0, 0, 1, 1, "rand_flush");
        for (int c = 0; c < 3000; c++) begin
            bit ws, wl, rs, rl, rk, fl, rstn;
            ws   = (m_wr_ready() && ($urandom_range(1, 0) == 1)) || ($urandom_range(39, 0) == 0);
            wl   = (m_wa && ($urandom_range(2, 0) == 0)) || ($urandom_range(39, 0) == 0);
            rs   = (m_rd_ready() && ($urandom_range(1, 0) == 1)) || ($urandom_range(39, 0) == 0);
            rl   = (m_ra && ($urandom_range(2, 0) == 0)) || ($urandom_range(39, 0) == 0);
            rk   = ($urandom_range(2, 0) == 0);
            fl   = ($urandom_range(79, 0) == 0);
            rstn = ($urandom_range(149, 0) != 0);
            apply_stimulus(ws, wl, rs, rl, rk, fl, rstn, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
